seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Mealy serial-pattern detector; next generation of the fixed "101" non-overlapping detector.
- Pattern and length are run-time programmable up to MAX_LEN bits.
- Overlapping or non-overlapping mode is selectable.
- Input is qualified by a valid strobe, and a saturating match counter is provided.
- Sits between the serial-bit source and downstream control/status logic. After reset it behaves as the legacy 101 non-overlapping detector.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..16).
- LEN_W, 5: width of cfg_len. Must hold MAX_LEN.
- CNT_W, 8: width of match_cnt.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_load  in  1  single-cycle strobe; latch cfg_pattern/cfg_len/cfg_overlap.
- cfg_pattern  in  MAX_LEN  pattern. Bit [len-1] is the first bit received; bit [0] is the last bit received.
- cfg_len  in  LEN_W  pattern length in bits. Legal range 2..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping detection; 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse when a cfg_load is rejected.
- d_valid  in  1  d is sampled only when this is high.
- d  in  1  serial data bit.
- z  out  1  Mealy match output (combinational from d/d_valid and current state).
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (rst high at clk edge):
  - pattern = 101, len = 3, overlap = 0.
  - history = 0, fill = 0, match_cnt = 0, cfg_err = 0.
  - z is forced to 0 while rst is high.
- State held:
  - hist[MAX_LEN-1:0]: shift register of accepted bits, newest bit in [0].
  - fill: number of valid history bits, saturating at MAX_LEN.
- Candidate window: {hist, d} restricted to its low len bits.
- Match condition:
  - z = d_valid & !cfg_load & !rst & (fill >= len-1) & (low len bits of {hist[len-2:0], d} == pattern[len-1:0]).
  - Zero latency: z is asserted in the same cycle as the completing bit.
- On a clk edge with d_valid=1 and no match:
  - hist <= {hist[MAX_LEN-2:0], d}.
  - fill <= min(fill+1, MAX_LEN).
- On a clk edge with a match:
  - match_cnt increments, saturating at 2^CNT_W-1 (no wrap).
  - overlap=1: shift as in the no-match case.
  - overlap=0: hist <= 0 and fill <= 0, so no bit of the matched window is reused.
- d_valid=0: hist, fill and match_cnt hold; z=0.
- Configuration:
  - cfg_load=1 with 2 <= cfg_len <= MAX_LEN: pattern, len and overlap update at this edge. hist and fill clear. match_cnt is retained.
  - Any d_valid in the cfg_load cycle is ignored (z=0, bit discarded).
  - cfg_load with cfg_len < 2 or cfg_len > MAX_LEN: configuration unchanged, history unchanged, the d bit in that cycle is discarded, cfg_err=1 on the next cycle for one cycle.
  - Pattern bits above len-1 are don't-care and are ignored in the compare.
- Simultaneous events: rst has priority over cfg_load, and cfg_load has priority over d_valid.
- Reset mid-stream: a partial match is lost; detection restarts from fill=0 with the 101 default.
- Internal FSM (2 states):
  - EMPTY (fill==0).
  - COLLECT (fill>0).
  - Transitions follow fill. A non-overlap match returns to EMPTY.

Decomposition:
- Shared package seq_det_pkg holds:
  - DEFAULT_PATTERN = 101, DEFAULT_LEN = 3, DEFAULT_OVERLAP = 0.
  - State enum {EMPTY, COLLECT}.
  - A function computing the length mask from len.
- One natural sub-module, seq_sat_counter (parametrised width, sync reset, inc enable, saturates). It is used for match_cnt and is reusable elsewhere.
- Compare/mask logic stays in the top module.

Test Plan:
- Defaults, non-overlap: after reset, stream d = 1,0,1,1,0,0,1,1,0,1,0,1,0,1 (all valid).
  - z pulses on bit indices 2, 9 and 13 (0-based).
  - match_cnt = 3.
- Overlap mode: load pattern 101, len 3, overlap 1; stream 1,0,1,0,1,0,1.
  - z high on indices 2, 4 and 6.
  - match_cnt increments by 3.
- Bit ordering and length: load pattern 0110_1100, len 8, overlap 0; stream 0,1,1,0,1,1,0,0.
  - z high only on the 8th bit.
  - Load pattern 110, len 3 and stream 0,1,1 -> no z.
- Valid gaps: pattern 101 default; 1 (valid), 0 (valid), three cycles with d_valid=0 and d=1, then 1 (valid).
  - z high only on the final valid cycle.
  - z=0 during the gap cycles.
- Config errors and priority:
  - cfg_load with cfg_len=1 -> cfg_err one-cycle pulse; the 101 pattern is still detected afterwards.
  - cfg_load coinciding with a completing bit -> z=0 and that bit is discarded.
  - rst asserted during a partial match 1,0 -> following 1 gives z=0.
- Saturation: CNT_W=2, overlap pattern 11, len 2; stream six 1s.
  - z high on bits 2 to 6.
  - match_cnt = 1,2,3,3,3 (stays at 3).

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared defaults, state encoding and mask helper
// for the programmable serial pattern detector.
package seq_det_pkg;

  localparam logic [15:0] DEFAULT_PATTERN = 16'b101;
  localparam int          DEFAULT_LEN     = 3;
  localparam logic        DEFAULT_OVERLAP = 1'b0;

  typedef enum logic {
    EMPTY,
    COLLECT
  } state_t;

  // Ones in the low len bits; len may reach 16.
  function automatic logic [15:0] len_mask(
    input int unsigned len
  );
    logic [16:0] m;
    m = (17'd1 << len) - 17'd1;
    return m[15:0];
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Up counter with synchronous reset that
// sticks at its all-ones value.
module seq_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Mealy detector for a run-time programmable
// serial pattern with optional overlap.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               d_valid,
  input  logic               d,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W:0]   ONE  = 1;
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LMIN = LEN_W'(2);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_cfg_err;
  state_t             r_state;

  logic [MAX_LEN-1:0] w_hist_nxt;
  logic [LEN_W-1:0]   w_fill_nxt;
  state_t             w_state_nxt;
  logic [15:0]        w_mask_full;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_win;
  logic               w_cfg_ok;
  logic               w_fill_ok;
  logic               w_eq;
  logic               w_fire;
  logic               w_z;

  assign w_cfg_ok = (cfg_len >= LMIN) &&
                    (cfg_len <= LMAX);

  assign w_mask_full = len_mask(32'(r_len));
  assign w_mask = w_mask_full[MAX_LEN-1:0];
  assign w_win  = {r_hist[MAX_LEN-2:0], d};
  assign w_eq   = ((w_win ^ r_pattern) & w_mask) == '0;

  // len >= 2, so fill >= len-1 already implies COLLECT.
  assign w_fill_ok = (r_state == COLLECT) &&
                     (({1'b0, r_fill} + ONE) >=
                      {1'b0, r_len});

  assign w_fire = d_valid & ~cfg_load & ~rst;
  assign w_z    = w_fire & w_fill_ok & w_eq;
  assign z      = w_z;

  always_comb begin
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_state_nxt = r_state;
    if (cfg_load) begin
      if (w_cfg_ok) begin
        w_hist_nxt  = '0;
        w_fill_nxt  = '0;
        w_state_nxt = EMPTY;
      end
    end else if (d_valid) begin
      if (w_z && !r_overlap) begin
        w_hist_nxt  = '0;
        w_fill_nxt  = '0;
        w_state_nxt = EMPTY;
      end else begin
        w_hist_nxt  = w_win;
        w_state_nxt = COLLECT;
        if (r_fill != LMAX) begin
          w_fill_nxt = r_fill + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= DEFAULT_PATTERN[MAX_LEN-1:0];
      r_len     <= LEN_W'(DEFAULT_LEN);
      r_overlap <= DEFAULT_OVERLAP;
      r_hist    <= '0;
      r_fill    <= '0;
      r_state   <= EMPTY;
      r_cfg_err <= 1'b0;
    end else begin
      r_hist    <= w_hist_nxt;
      r_fill    <= w_fill_nxt;
      r_state   <= w_state_nxt;
      r_cfg_err <= cfg_load & ~w_cfg_ok;
      if (cfg_load && w_cfg_ok) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
      end
    end
  end

  assign cfg_err = r_cfg_err;

  seq_sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_inc(w_z),
    .o_cnt(match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: main detector plus a 2-bit
// counter copy for saturation.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [4:0] cfg_len;
  logic       cfg_overlap;
  logic       d_valid;
  logic       d;
  logic       cfg_err, cfg_err2;
  logic       z, z2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .MAX_LEN(8), .LEN_W(5), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_err(cfg_err),
    .d_valid(d_valid), .d(d),
    .z(z), .match_cnt(match_cnt)
  );

  seq_detector_param #(
    .MAX_LEN(8), .LEN_W(5), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_err(cfg_err2),
    .d_valid(d_valid), .d(d),
    .z(z2), .match_cnt(match_cnt2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 0; cfg_load = 0; d_valid = 0; d = 0;
  endtask

  task automatic drv(
    input logic       r,
    input logic       cl,
    input logic [7:0] pat,
    input logic [4:0] len,
    input logic       ov,
    input logic       v,
    input logic       b
  );
    @(negedge clk);
    rst = r; cfg_load = cl;
    cfg_pattern = pat; cfg_len = len;
    cfg_overlap = ov; d_valid = v; d = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic bit_z(
    input logic  v,
    input logic  b,
    input logic  ez,
    input string tag
  );
    drv(0, 0, 8'h00, 5'd0, 0, v, b);
    chk(tag, 32'(z), 32'(ez));
    tick();
  endtask

  task automatic load(
    input logic [7:0] pat,
    input logic [4:0] len,
    input logic       ov
  );
    drv(0, 1, pat, len, ov, 0, 0);
    tick();
  endtask

  task automatic do_rst();
    drv(1, 0, 8'h00, 5'd0, 0, 1, 1);
    chk("z_in_rst", 32'(z), 32'd0);
    tick();
  endtask

  logic [13:0] s1_d = 14'b10110011010101;
  logic [13:0] s1_z = 14'b00100000010001;
  logic [7:0]  s3_d = 8'b01101100;
  logic [5:0]  s6_z = 6'b011111;
  logic [1:0]  s6_c [6] = '{0, 1, 2, 3, 3, 3};

  initial begin
    idle();
    cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
    repeat (2) @(posedge clk);

    do_rst();
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);

    // default 101, non-overlapping
    for (int i = 0; i < 14; i++)
      bit_z(1, s1_d[13-i], s1_z[13-i],
            $sformatf("dflt_z%0d", i));
    chk("dflt_cnt", 32'(match_cnt), 32'd3);

    load(8'b101, 5'd3, 1);
    for (int i = 0; i < 7; i++)
      bit_z(1, ~i[0], (i >= 2) && !i[0],
            $sformatf("ovl_z%0d", i));
    chk("ovl_cnt", 32'(match_cnt), 32'd6);

    load(8'b0110_1100, 5'd8, 0);
    for (int i = 0; i < 8; i++)
      bit_z(1, s3_d[7-i], i == 7,
            $sformatf("len8_z%0d", i));
    chk("len8_cnt", 32'(match_cnt), 32'd7);

    load(8'b110, 5'd3, 0);
    bit_z(1, 0, 0, "ord_z0");
    bit_z(1, 1, 0, "ord_z1");
    bit_z(1, 1, 0, "ord_z2");
    chk("ord_cnt", 32'(match_cnt), 32'd7);

    // valid gaps with the default pattern
    do_rst();
    bit_z(1, 1, 0, "gap_a");
    bit_z(1, 0, 0, "gap_b");
    for (int i = 0; i < 3; i++)
      bit_z(0, 1, 0, $sformatf("gap_idle%0d", i));
    bit_z(1, 1, 1, "gap_c");
    chk("gap_cnt", 32'(match_cnt), 32'd1);

    // rejected load keeps history, discards bit
    bit_z(1, 1, 0, "bad1_a");
    bit_z(1, 0, 0, "bad1_b");
    drv(0, 1, 8'h00, 5'd1, 1, 1, 0);
    chk("bad1_z", 32'(z), 32'd0);
    tick();
    chk("bad1_err", 32'(cfg_err), 32'd1);
    bit_z(1, 1, 1, "bad1_c");
    chk("bad1_err_off", 32'(cfg_err), 32'd0);

    bit_z(1, 1, 0, "bad9_a");
    drv(0, 1, 8'hFF, 5'd9, 1, 1, 1);
    chk("bad9_z", 32'(z), 32'd0);
    tick();
    chk("bad9_err", 32'(cfg_err), 32'd1);
    bit_z(1, 0, 0, "bad9_b");
    bit_z(1, 1, 1, "bad9_c");
    chk("bad_cnt", 32'(match_cnt), 32'd3);

    // accepted load on the completing bit
    bit_z(1, 1, 0, "co_a");
    bit_z(1, 0, 0, "co_b");
    drv(0, 1, 8'b101, 5'd3, 0, 1, 1);
    chk("co_z", 32'(z), 32'd0);
    tick();
    chk("co_err", 32'(cfg_err), 32'd0);
    bit_z(1, 0, 0, "co_c");
    bit_z(1, 1, 0, "co_d");
    chk("co_cnt", 32'(match_cnt), 32'd3);

    // reset drops a partial 1,0
    bit_z(1, 1, 0, "rp_a");
    bit_z(1, 0, 0, "rp_b");
    do_rst();
    bit_z(1, 1, 0, "rp_c");
    chk("rp_cnt", 32'(match_cnt), 32'd0);

    // saturation on the 2-bit counter copy
    do_rst();
    load(8'hF3, 5'd2, 1);
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 8'h00, 5'd0, 0, 1, 1);
      chk($sformatf("sat_z%0d", i),
          32'(z2), 32'(s6_z[5-i]));
      tick();
      chk($sformatf("sat_cnt%0d", i),
          32'(match_cnt2), 32'(s6_c[i]));
    end
    chk("sat_wide", 32'(match_cnt), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
